// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with single-cycle logic/arith ops and iterative shifts
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow,
    output logic             carryout,
    output logic             negative,
    output logic             illegal,
    output logic             busy
);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;

    state_t           state, state_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [SHW-1:0]   cnt, cnt_nx;
    logic [1:0]       sop, sop_nx;

    logic             wr;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v, res_i;

    logic             accept;
    logic [SHW-1:0]   k;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             c_msb_in;

    // Shift kind encoding follows op[1:0]: 0 = SLL, 1 = SRL, 2 = SRA
    function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] kind, input logic [WIDTH-1:0] v);
        case (kind)
            2'd0:    return {v[WIDTH-2:0], 1'b0};
            2'd1:    return {1'b0, v[WIDTH-1:1]};
            default: return {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    function automatic logic shift_out(input logic [1:0] kind, input logic [WIDTH-1:0] v);
        return (kind == 2'd0) ? v[WIDTH-1] : v[0];
    endfunction

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign busy     = (state == SHIFT);
    assign accept   = in_valid && in_ready;
    assign k        = bus_b[SHW-1:0];

    // Shared adder: SUB is A + ~B + 1, overflow from carry into vs. out of the MSB
    always_comb begin
        is_sub   = (op == OP_SUB);
        b_eff    = is_sub ? ~bus_b : bus_b;
        sum      = {1'b0, bus_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        c_msb_in = bus_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
    end

    // Next-state, shift datapath and result selection
    always_comb begin
        state_nx = state;
        work_nx  = work;
        cnt_nx   = cnt;
        sop_nx   = sop;
        wr       = 1'b0;
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        res_i    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    wr = 1'b1;
                    case (op)
                        OP_ADD, OP_SUB: begin
                            res   = sum[WIDTH-1:0];
                            res_c = sum[WIDTH];
                            res_v = c_msb_in ^ sum[WIDTH];
                        end
                        OP_AND:  res = bus_a & bus_b;
                        OP_OR:   res = bus_a | bus_b;
                        OP_NOR:  res = ~(bus_a | bus_b);
                        OP_XOR:  res = bus_a ^ bus_b;
                        OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(bus_a) < $signed(bus_b))};
                        OP_SLTU: res = {{(WIDTH-1){1'b0}}, (bus_a < bus_b)};
                        OP_SLL, OP_SRL, OP_SRA: begin
                            if (k == '0) begin
                                res = bus_a;
                            end else if (k == SHW'(1)) begin
                                res   = shift_one(op[1:0], bus_a);
                                res_c = shift_out(op[1:0], bus_a);
                            end else begin
                                // Longer shifts finish in SHIFT; nothing is written now
                                wr       = 1'b0;
                                work_nx  = shift_one(op[1:0], bus_a);
                                cnt_nx   = k - SHW'(1);
                                sop_nx   = op[1:0];
                                state_nx = SHIFT;
                            end
                        end
                        default: res_i = 1'b1;
                    endcase
                end
            end
            SHIFT: begin
                work_nx = shift_one(sop, work);
                cnt_nx  = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    wr       = 1'b1;
                    res      = shift_one(sop, work);
                    res_c    = shift_out(sop, work);
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM and shift working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            sop   <= 2'd0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            cnt   <= cnt_nx;
            sop   <= sop_nx;
        end
    end

    // Output register: a new result wins over a simultaneous drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carryout  <= 1'b0;
            negative  <= 1'b0;
            illegal   <= 1'b0;
        end else if (wr) begin
            out_valid <= 1'b1;
            out       <= res;
            zero      <= (res == '0);
            overflow  <= res_v;
            carryout  <= res_c;
            negative  <= res[WIDTH-1];
            illegal   <= res_i;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
